// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small word FIFO.
//
// Words pushed into the FIFO are serialised onto tx as
// start / DATA_BITS data (LSB first) / optional parity / STOP_BITS stop.
// Frames are sent back-to-back, with no idle gap, while the FIFO holds data.
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-high reset
//   wr_en     push request (ignored and flagged as overflow while full)
//   wr_data   word to transmit
//   full      FIFO holds FIFO_DEPTH entries (registered)
//   count     FIFO occupancy
//   overflow  one-cycle pulse after a dropped push
//   busy      a frame is on the line
//   tx        serial output, idles high
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [DATA_BITS-1:0]          wr_data,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          busy,
  output logic                          tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] TIMER_END = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count_n;
  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] head;

  assign push = wr_en && !full;
  assign head = mem[rd_ptr];

  always_comb begin
    count_n = count;
    case ({push, pop})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
  end

  // Storage needs no reset; only pointers and flags are cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // full is registered, so a push that meets full is dropped even when a
  // pop frees an entry on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en && full;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_n;
      full     <= (count_n == FULL_CNT);
    end
  end

  // ---------------------------------------------------------------- FSM
  state_t               state;
  state_t               state_n;
  logic [TW-1:0]        timer;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 timer_end;
  logic                 tx_n;
  logic                 busy_n;

  assign timer_end = (timer == TIMER_END);

  // tx and busy are registered from the current state, so the line follows
  // the state by one clock: pop at edge N+1 puts the start bit out at N+2.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    tx_n    = 1'b1;
    busy_n  = 1'b1;
    case (state)
      S_IDLE: begin
        busy_n = 1'b0;
        if (count != '0) begin
          pop     = 1'b1;
          state_n = S_START;
        end
      end
      S_START: begin
        tx_n = 1'b0;
        if (timer_end) state_n = S_DATA;
      end
      S_DATA: begin
        tx_n = shreg[0];
        if (timer_end && (bit_idx == LAST_DATA))
          state_n = (PARITY != 0) ? S_PAR : S_STOP;
      end
      S_PAR: begin
        tx_n = par_bit;
        if (timer_end) state_n = S_STOP;
      end
      S_STOP: begin
        if (timer_end && (bit_idx == LAST_STOP)) begin
          if (count != '0) begin
            pop     = 1'b1;
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      timer   <= '0;
      bit_idx <= '0;
    end else begin
      state <= state_n;
      tx    <= tx_n;
      busy  <= busy_n;
      if ((state == S_IDLE) || timer_end) timer <= '0;
      else                                timer <= timer + 1'b1;
      // bit_idx counts data bits in DATA and stop bits in STOP.
      if (state_n != state) bit_idx <= '0;
      else if (timer_end)   bit_idx <= bit_idx + 1'b1;
    end
  end

  // Word and parity are latched at pop, isolating the frame from later writes.
  always_ff @(posedge clk) begin
    if (pop) begin
      shreg   <= head;
      par_bit <= (PARITY == 1) ? ~^head : ^head;
    end else if ((state == S_DATA) && timer_end) begin
      shreg <= shreg >> 1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: four differently configured instances, each
// checked every cycle against a frame-level model, plus literal checks.
module tb_uart_tx_fifo;

  function automatic int cfg_cpb(input int i);
    return (i == 3) ? 217 : 4;
  endfunction
  function automatic int cfg_db(input int i);
    return (i == 3) ? 7 : 8;
  endfunction
  function automatic int cfg_par(input int i);
    return (i == 1) ? 2 : ((i == 2) ? 1 : 0);
  endfunction
  function automatic int cfg_stop(input int i);
    return (i == 3) ? 2 : 1;
  endfunction

  logic       clk;
  logic       rst_v     [4];
  logic       wr_en_v   [4];
  logic [8:0] wr_data_v [4];
  logic       full_v    [4];
  logic       ovf_v     [4];
  logic       busy_v    [4];
  logic       tx_v      [4];
  logic [2:0] cnt_v     [4];

  int n_checks = 0;
  int n_errors = 0;

  bit s_tx   [2400];
  bit s_busy [2400];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 4; g++) begin : cfg
    localparam int C = cfg_cpb(g);
    localparam int D = cfg_db(g);
    localparam int P = cfg_par(g);
    localparam int S = cfg_stop(g);
    localparam int L = (1 + D + ((P != 0) ? 1 : 0) + S) * C;

    uart_tx_fifo #(
      .CLKS_PER_BIT(C),
      .DATA_BITS   (D),
      .PARITY      (P),
      .STOP_BITS   (S),
      .FIFO_DEPTH  (4)
    ) dut (
      .clk     (clk),
      .reset   (rst_v[g]),
      .wr_en   (wr_en_v[g]),
      .wr_data (wr_data_v[g][D-1:0]),
      .full    (full_v[g]),
      .count   (cnt_v[g]),
      .overflow(ovf_v[g]),
      .busy    (busy_v[g]),
      .tx      (tx_v[g])
    );

    // Model: a queue of accepted words and a countdown of line cycles left
    // in the frame being sent; the line level is derived from the frame
    // position. Expected outputs after each edge reflect the frame position
    // before that edge.
    int q[$];
    int rem  = 0;
    int word = 0;
    bit live = 0;
    bit e_tx = 1, e_busy = 0, e_full = 0, e_ovf = 0;
    int e_cnt = 0;

    initial begin : model
      int  slot;
      bit  full_before;
      forever begin
        @(posedge clk);
        if (rst_v[g]) begin
          q.delete();
          rem = 0; e_tx = 1; e_busy = 0; e_full = 0; e_ovf = 0; e_cnt = 0;
          live = 1;
        end else begin
          if (rem == 0) begin
            e_tx = 1; e_busy = 0;
          end else begin
            slot   = (L - rem) / C;
            e_busy = 1;
            if (slot == 0)                       e_tx = 0;
            else if (slot <= D)                  e_tx = ((word >> (slot - 1)) & 1) != 0;
            else if ((P != 0) && (slot == D + 1)) e_tx = (P == 1) ? ($countones(word) % 2 == 0)
                                                                   : ($countones(word) % 2 == 1);
            else                                 e_tx = 1;
          end
          full_before = (q.size() == 4);
          if ((rem <= 1) && (q.size() != 0)) begin
            word = q.pop_front();
            rem  = L;
          end else if (rem > 0) begin
            rem--;
          end
          e_ovf = wr_en_v[g] && full_before;
          if (wr_en_v[g] && !full_before) q.push_back(int'(wr_data_v[g]) & ((1 << D) - 1));
          e_cnt  = q.size();
          e_full = (q.size() == 4);
        end
      end
    end

    initial begin : compare
      forever begin
        @(negedge clk);
        if (live) begin
          chk($sformatf("cfg%0d.tx", g),       int'(tx_v[g]),   int'(e_tx));
          chk($sformatf("cfg%0d.busy", g),     int'(busy_v[g]), int'(e_busy));
          chk($sformatf("cfg%0d.count", g),    int'(cnt_v[g]),  e_cnt);
          chk($sformatf("cfg%0d.full", g),     int'(full_v[g]), int'(e_full));
          chk($sformatf("cfg%0d.overflow", g), int'(ovf_v[g]),  int'(e_ovf));
        end
      end
    end
  end

  task automatic drive(input int g, input bit en, input logic [8:0] d);
    @(negedge clk);
    wr_en_v[g]   = en;
    wr_data_v[g] = d;
  endtask

  // s_tx[0]/s_busy[0] are taken at the current negedge.
  task automatic record(input int g, input int n);
    for (int i = 0; i < n; i++) begin
      if (i != 0) @(negedge clk);
      s_tx[i]   = tx_v[g];
      s_busy[i] = busy_v[g];
    end
  endtask

  function automatic int busy_sum(input int a, input int b);
    int s = 0;
    for (int i = a; i <= b; i++) s += int'(s_busy[i]);
    return s;
  endfunction

  function automatic int tx_sum(input int a, input int b);
    int s = 0;
    for (int i = a; i <= b; i++) s += int'(s_tx[i]);
    return s;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit bits34 [8];
    bit bits33 [7];
    int n_ovf, max_c, n_busy, n_full, n_bad;
    bits34 = '{0, 0, 1, 0, 1, 1, 0, 0};
    bits33 = '{1, 1, 0, 0, 1, 1, 0};

    for (int g = 0; g < 4; g++) begin
      rst_v[g] = 1'b1; wr_en_v[g] = 1'b0; wr_data_v[g] = '0;
    end
    repeat (3) @(negedge clk);
    chk("reset.tx",    int'(tx_v[0]),   1);
    chk("reset.busy",  int'(busy_v[0]), 0);
    chk("reset.count", int'(cnt_v[0]),  0);
    chk("reset.full",  int'(full_v[0]), 0);
    for (int g = 0; g < 4; g++) rst_v[g] = 1'b0;
    repeat (2) @(negedge clk);

    // Single frame 8'h34, 4 clocks per bit.
    drive(0, 1, 9'h034);
    @(negedge clk);
    wr_en_v[0] = 1'b0;
    chk("t1.count_after_push", int'(cnt_v[0]), 1);
    record(0, 60);
    chk("t1.tx_before_start", int'(s_tx[1]), 1);
    chk("t1.tx_start",        int'(s_tx[2]), 0);
    for (int b = 0; b < 8; b++)
      chk($sformatf("t1.bit%0d", b), int'(s_tx[2 + 4 * (b + 1) + 1]), int'(bits34[b]));
    chk("t1.stop",      int'(s_tx[39]), 1);
    chk("t1.busy_len",  busy_sum(0, 59), 40);
    chk("t1.busy_last", int'(s_busy[41]), 1);
    chk("t1.busy_end",  int'(s_busy[42]), 0);

    // Parity: bit slot 9 sampled mid-bit at index 39.
    drive(1, 1, 9'h035); @(negedge clk); wr_en_v[1] = 1'b0;
    record(1, 60);
    chk("t2.even_35_parity", int'(s_tx[39]), 0);
    chk("t2.even_35_len",    busy_sum(0, 59), 44);
    drive(2, 1, 9'h035); @(negedge clk); wr_en_v[2] = 1'b0;
    record(2, 60);
    chk("t2.odd_35_parity",  int'(s_tx[39]), 1);
    chk("t2.odd_35_len",     busy_sum(0, 59), 44);
    drive(1, 1, 9'h02F); @(negedge clk); wr_en_v[1] = 1'b0;
    record(1, 60);
    chk("t2.even_2F_parity", int'(s_tx[39]), 1);

    // Back-to-back: index j of the record is sample N+2+j.
    drive(0, 1, 9'h039);
    @(negedge clk); chk("t3.count0", int'(cnt_v[0]), 1); wr_data_v[0] = 9'h039;
    @(negedge clk); chk("t3.count1", int'(cnt_v[0]), 1); wr_data_v[0] = 9'h02A;
    @(negedge clk); chk("t3.count2", int'(cnt_v[0]), 2); wr_en_v[0] = 1'b0;
    record(0, 200);
    chk("t3.busy_total", busy_sum(0, 199), 120);
    chk("t3.busy_run",   busy_sum(0, 119), 120);
    chk("t3.stop1",      int'(s_tx[39]), 1);
    chk("t3.start2",     int'(s_tx[40]), 0);
    chk("t3.start3",     int'(s_tx[80]), 0);
    chk("t3.drained",    int'(cnt_v[0]), 0);

    // Overflow: seven consecutive pushes from idle.
    drive(0, 1, 9'h041);
    n_ovf = 0; max_c = 0; n_busy = 0; n_full = 0;
    for (int k = 1; k <= 227; k++) begin
      @(negedge clk);
      if (k < 7) wr_data_v[0] = 9'(9'h041 + k);
      else       wr_en_v[0]   = 1'b0;
      n_ovf  += int'(ovf_v[0]);
      n_busy += int'(busy_v[0]);
      n_full += int'(full_v[0]);
      if (int'(cnt_v[0]) > max_c) max_c = int'(cnt_v[0]);
    end
    chk("t4.overflow_pulses", n_ovf, 2);
    chk("t4.max_count",       max_c, 4);
    chk("t4.full_seen",       (n_full > 0) ? 1 : 0, 1);
    chk("t4.busy_5_frames",   n_busy, 200);

    // Reset during data bit 3 of 8'h30 with two words queued.
    drive(0, 1, 9'h030);
    @(negedge clk); wr_data_v[0] = 9'h031;
    @(negedge clk); wr_data_v[0] = 9'h032;
    @(negedge clk); wr_en_v[0] = 1'b0;
    repeat (16) @(negedge clk);
    chk("t5.bit3_low",     int'(tx_v[0]),  0);
    chk("t5.queued",       int'(cnt_v[0]), 2);
    rst_v[0] = 1'b1;
    @(negedge clk);
    rst_v[0] = 1'b0;
    chk("t5.tx_after",    int'(tx_v[0]),   1);
    chk("t5.busy_after",  int'(busy_v[0]), 0);
    chk("t5.count_after", int'(cnt_v[0]),  0);
    n_bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (busy_v[0] || !tx_v[0]) n_bad++;
    end
    chk("t5.stays_idle", n_bad, 0);

    // 7 data bits, 2 stop bits, 217 clocks per bit.
    drive(3, 1, 9'h033); @(negedge clk); wr_en_v[3] = 1'b0;
    record(3, 2200);
    chk("t6.tx_start", int'(s_tx[2]), 0);
    for (int b = 0; b < 7; b++)
      chk($sformatf("t6.bit%0d", b), int'(s_tx[2 + 217 * (b + 1) + 108]), int'(bits33[b]));
    chk("t6.last_data",  int'(s_tx[1737]), 0);
    chk("t6.stop_high",  tx_sum(1738, 2171), 434);
    chk("t6.frame_len",  busy_sum(0, 2199), 2170);
    chk("t6.busy_end",   int'(s_busy[2172]), 0);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an input FIFO. It is the synthesizable, configurable successor to the byte serializer used to drive RXD in SoC benches. Bus masters or bench stimulus push words into the FIFO, and the block serializes them onto `tx` with configurable bit period, data width, parity and stop bits. Frames go out back-to-back with no idle gap while the FIFO holds data. It sits beside the SoC UART receiver, either as the SoC TX path or as a loopback stimulus source.

Parameters:
- CLKS_PER_BIT, 217, clock cycles per UART bit (25 MHz / 115200); legal range is 2 or more.
- DATA_BITS, 8, payload bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.
- FIFO_DEPTH, 4, FIFO entries; must be a power of 2 and 2 or more.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  push request.
- wr_data  input  DATA_BITS  word to transmit.
- full  output  1  FIFO holds FIFO_DEPTH entries.
- count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- overflow  output  1  one-cycle pulse when a push is dropped.
- busy  output  1  a frame is on the line.
- tx  output  1  serial line; idle level is high.

Behaviour:
- Reset is one clock; the block is one clock domain with synchronous, active-high reset.
- Reset values: tx=1, busy=0, full=0, count=0, overflow=0, state=IDLE. FIFO pointers are cleared; data contents are don't-care.
- Reset asserted mid-frame: tx is 1 on the next cycle, the frame is aborted, and queued words are discarded.
- Push: when wr_en=1 and full=0 at a rising edge, wr_data is stored and count increments.
- Push while full=1: the word is dropped and overflow=1 for exactly the next cycle. This holds even if a pop happens in the same cycle, because full is a registered flag.
- Simultaneous push and pop with full=0: count is unchanged and both operations take effect.
- Pointers wrap modulo FIFO_DEPTH. full = (count==FIFO_DEPTH).
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> (START or IDLE).
  - IDLE: tx=1, busy=0. If count!=0, pop the head into the shift register, compute parity, and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: DATA_BITS bits, LSB first, each held CLKS_PER_BIT cycles. A bit index counts 0..DATA_BITS-1.
  - PARITY: only when PARITY!=0. Odd mode: tx = ~^data. Even mode: tx = ^data. Held for CLKS_PER_BIT cycles.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. On the last cycle, if count!=0, pop and go directly to START (zero idle gap); otherwise go to IDLE.
- Bit timer: counts 0..CLKS_PER_BIT-1 and reloads on every bit boundary. There is no drift; a frame lasts exactly (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
- busy=1 from the first START cycle through the last STOP cycle.
- Latency: a push at edge N into an empty FIFO with state=IDLE gives count=1 after edge N. The pop happens at edge N+1, and tx=0 from edge N+2.
- Data words are latched at pop; later FIFO writes do not disturb the frame in flight.

Test Plan:
1. Single frame. With CLKS_PER_BIT=4, DATA_BITS=8, PARITY=0, STOP_BITS=1, push 8'h34. Required: tx=0 two cycles after the push, then bits 0,0,1,0,1,1,0,0 at 4 cycles each, then stop 1. busy is high for exactly 40 cycles, and tx returns to idle.
2. Parity. With PARITY=2, push 8'h35 (four ones): the parity bit is 0. With PARITY=1, push 8'h35: the parity bit is 1. With PARITY=2, push 8'h2F (five ones): the parity bit is 1. Each frame lasts 11*CLKS_PER_BIT cycles.
3. Back-to-back. Push 8'h39, 8'h39, 8'h2A on consecutive cycles. Required: three frames with no idle cycle between the stop bit and the next start bit. busy stays high continuously for 3 frame lengths. count goes 1,1,2 and then drains to 0.
4. Overflow. With FIFO_DEPTH=4, push 7 words on consecutive cycles starting from idle. The first word pops immediately, so 5 words are accepted and full=1. Required: overflow pulses once per dropped push (2 pulses), only the first 5 words are transmitted, in order, and count never exceeds 4.
5. Reset mid-frame. Assert reset during DATA bit 3 of 8'h30 with 2 words queued. Required: tx=1, busy=0 and count=0 on the next cycle, and no further frames start without new pushes.
6. Config sweep. Use DATA_BITS=7, STOP_BITS=2, CLKS_PER_BIT=217 and push 7'h33. Required: 7 data bits LSB first, a stop interval of exactly 434 cycles high, and a total frame of 10*217 cycles.
